// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types, response codes and the byte-strobe merge helper
// used by the interface and the register bank.
package axi_lite_pkg;

  localparam int DATA_BYTES = 4;
  localparam int ADDR_LSB   = 2;

  typedef logic [31:0]           addr_t;
  typedef logic [31:0]           data_t;
  typedef logic [DATA_BYTES-1:0] strb_t;
  typedef logic [1:0]            resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  function automatic data_t apply_strb(data_t old_val, data_t new_val, strb_t strb);
    data_t res;
    res = old_val;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (strb[k]) res[8*k +: 8] = new_val[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle (no prot signals) with master and slave views.
interface axi_lite_if;
  import axi_lite_pkg::*;

  addr_t awaddr;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;
  addr_t araddr;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register bank: independent AW/W capture, strobed writes with a
// one-cycle write pulse per register, and a registered read path.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int    NUM_REGS  = 16,
  parameter addr_t BASE_ADDR = 32'h0000_0000,
  parameter data_t RESET_VAL = 32'h0
) (
  input  logic                     aclk,
  input  logic                     resetn,
  axi_lite_if.slave                s_axi,
  output logic [NUM_REGS*32-1:0]   reg_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o
);

  localparam int    IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam addr_t SPAN  = addr_t'(NUM_REGS * DATA_BYTES);

  logic              aw_held_q, aw_held_d;
  addr_t             aw_addr_q, aw_addr_d;
  logic              w_held_q,  w_held_d;
  data_t             w_data_q,  w_data_d;
  strb_t             w_strb_q,  w_strb_d;
  logic              bvalid_q,  bvalid_d;
  resp_t             bresp_q,   bresp_d;
  logic              rvalid_q,  rvalid_d;
  data_t             rdata_q,   rdata_d;
  resp_t             rresp_q,   rresp_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  data_t             regs_q [NUM_REGS];
  data_t             regs_d [NUM_REGS];

  logic       aw_ready, w_ready, ar_ready;
  logic       aw_hs, w_hs, ar_hs, commit;
  addr_t      wr_addr, wr_off, rd_off;
  data_t      wr_data;
  strb_t      wr_strb;
  logic       wr_in_range, rd_in_range;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  // Readies are gated by resetn so nothing is accepted while in reset.
  assign aw_ready = resetn & ~aw_held_q & ~bvalid_q;
  assign w_ready  = resetn & ~w_held_q  & ~bvalid_q;
  assign ar_ready = resetn & ~rvalid_q;

  assign aw_hs = s_axi.awvalid & aw_ready;
  assign w_hs  = s_axi.wvalid  & w_ready;
  assign ar_hs = s_axi.arvalid & ar_ready;

  // Use the held copy if one exists, otherwise whatever is handshaking now.
  assign wr_addr = aw_held_q ? aw_addr_q : s_axi.awaddr;
  assign wr_data = w_held_q  ? w_data_q  : s_axi.wdata;
  assign wr_strb = w_held_q  ? w_strb_q  : s_axi.wstrb;
  assign commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs);

  assign wr_off      = wr_addr - BASE_ADDR;
  assign rd_off      = s_axi.araddr - BASE_ADDR;
  assign wr_in_range = wr_off < SPAN;
  assign rd_in_range = rd_off < SPAN;
  assign wr_idx      = wr_off[ADDR_LSB +: IDX_W];
  assign rd_idx      = rd_off[ADDR_LSB +: IDX_W];

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    aw_held_d  = aw_held_q;
    aw_addr_d  = aw_addr_q;
    w_held_d   = w_held_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = s_axi.awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = s_axi.wdata;
      w_strb_d = s_axi.wstrb;
    end
    if (bvalid_q && s_axi.bready) bvalid_d = 1'b0;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
      if (wr_in_range) begin
        regs_d[wr_idx]     = apply_strb(regs_q[wr_idx], wr_data, wr_strb);
        wr_pulse_d[wr_idx] = 1'b1;
      end
    end
  end

  // Reads sample regs_q, so a read on the same edge as a commit sees the old value.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s_axi.rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_in_range ? regs_q[rd_idx] : '0;
      rresp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      aw_held_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      // NOTE: the register array is reset because software relies on known control values.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      aw_held_q  <= aw_held_d;
      aw_addr_q  <= aw_addr_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  assign s_axi.awready = aw_ready;
  assign s_axi.wready  = w_ready;
  assign s_axi.arready = ar_ready;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign wr_pulse_o    = wr_pulse_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
    assign reg_o[32*i +: 32] = regs_q[i];
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile (NUM_REGS=16, BASE_ADDR=0, RESET_VAL=0);
// expected values are hand-computed and held in a small register model.
module tb_axi_lite_regfile;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [511:0]  reg_o;
  logic [15:0]   wr_pulse;
  logic [31:0]   exp_regs [16];
  int            total = 0;
  int            bad   = 0;
  logic [1:0]    resp;
  logic [15:0]   pulse;
  logic [31:0]   rd;

  axi_lite_if bus ();

  axi_lite_regfile dut (
    .aclk       (clk),
    .resetn     (rst_n),
    .s_axi      (bus),
    .reg_o      (reg_o),
    .wr_pulse_o (wr_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [511:0] flat();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = exp_regs[i];
    return v;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] r, output logic [15:0] p);
    int n;
    bus.awvalid = 1'b1; bus.awaddr = addr;
    bus.wvalid  = 1'b1; bus.wdata  = data; bus.wstrb = strb;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 10) begin tick(); n++; end
    check("wr_bvalid_wait", bus.bvalid, 1'b1);
    r = bus.bresp; p = wr_pulse;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    int n;
    bus.arvalid = 1'b1; bus.araddr = addr;
    tick();
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 10) begin tick(); n++; end
    check("rd_rvalid_wait", bus.rvalid, 1'b1);
    d = bus.rdata; r = bus.rresp;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0;
    bus.bready = 0; bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
    for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
    check("rst_valids", {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}, 6'b0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_regs", reg_o, flat());
    check("rst_pulse", wr_pulse, 16'h0);
    rst_n = 1'b1;
    #1;
    check("post_rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
    tick();

    // Same-cycle AW+W to 0x4
    bus.awvalid = 1; bus.awaddr = 32'h4; bus.wvalid = 1; bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF;
    tick();
    bus.awvalid = 0; bus.wvalid = 0;
    exp_regs[1] = 32'hDEAD_BEEF;
    check("t1_bvalid", bus.bvalid, 1'b1);
    check("t1_bresp", bus.bresp, 2'b00);
    check("t1_regs", reg_o, flat());
    check("t1_pulse", wr_pulse, 16'h0002);
    tick();
    check("t1_pulse_gone", wr_pulse, 16'h0);
    check("t1_bvalid_hold", bus.bvalid, 1'b1);
    bus.bready = 1;
    tick();
    bus.bready = 0;
    check("t1_b_done", {bus.bvalid, bus.awready, bus.wready}, 3'b011);

    // W three cycles ahead of AW, strobe 0101
    do_write(32'h8, 32'hAABB_CCDD, 4'hF, resp, pulse);
    exp_regs[2] = 32'hAABB_CCDD;
    check("t2_pre_resp", resp, 2'b00);
    check("t2_pre_pulse", pulse, 16'h0004);
    bus.wvalid = 1; bus.wdata = 32'h1122_3344; bus.wstrb = 4'b0101;
    tick();
    bus.wvalid = 0;
    check("t2_w_held", {bus.wready, bus.awready, bus.bvalid}, 3'b010);
    tick();
    tick();
    check("t2_no_commit", {bus.bvalid, wr_pulse}, 17'h0);
    check("t2_regs_unchanged", reg_o, flat());
    bus.awvalid = 1; bus.awaddr = 32'h8;
    tick();
    bus.awvalid = 0;
    exp_regs[2] = 32'hAA22_CC44;
    check("t2_bvalid", bus.bvalid, 1'b1);
    check("t2_regs", reg_o, flat());
    check("t2_pulse", wr_pulse, 16'h0004);
    bus.bready = 1;
    tick();
    bus.bready = 0;

    // Out-of-range write and read
    do_write(32'h40, 32'h1234_5678, 4'hF, resp, pulse);
    check("t3_bresp", resp, 2'b10);
    check("t3_pulse", pulse, 16'h0);
    check("t3_regs", reg_o, flat());
    do_read(32'h40, rd, resp);
    check("t3_rdata", rd, 32'h0);
    check("t3_rresp", resp, 2'b10);
    do_read(32'h4, rd, resp);
    check("t3_rd4", {rd, resp}, {32'hDEAD_BEEF, 2'b00});

    // Back-pressure on B and R
    bus.awvalid = 1; bus.awaddr = 32'hC; bus.wvalid = 1; bus.wdata = 32'h0F0F_0F0F; bus.wstrb = 4'hF;
    tick();
    bus.awvalid = 0; bus.wvalid = 0;
    exp_regs[3] = 32'h0F0F_0F0F;
    check("t4_pulse", wr_pulse, 16'h0008);
    for (int i = 0; i < 5; i++) begin
      check("t4_b_stall", {bus.awready, bus.wready, bus.bvalid}, 3'b001);
      tick();
    end
    bus.bready = 1;
    tick();
    bus.bready = 0;
    check("t4_b_free", {bus.awready, bus.wready, bus.bvalid}, 3'b110);
    bus.arvalid = 1; bus.araddr = 32'hC;
    tick();
    bus.arvalid = 0;
    for (int i = 0; i < 4; i++) begin
      check("t4_r_stall", {bus.rvalid, bus.arready, bus.rdata}, {2'b10, 32'h0F0F_0F0F});
      tick();
    end
    bus.rready = 1;
    tick();
    bus.rready = 0;
    check("t4_r_free", {bus.rvalid, bus.arready}, 2'b01);

    // Read/write collision on register 1
    do_write(32'h4, 32'h1, 4'hF, resp, pulse);
    exp_regs[1] = 32'h1;
    bus.awvalid = 1; bus.awaddr = 32'h4; bus.wvalid = 1; bus.wdata = 32'h5; bus.wstrb = 4'hF;
    bus.arvalid = 1; bus.araddr = 32'h4;
    tick();
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    exp_regs[1] = 32'h5;
    check("t5_both_valid", {bus.bvalid, bus.rvalid}, 2'b11);
    check("t5_old_rdata", {bus.rdata, bus.rresp}, {32'h1, 2'b00});
    check("t5_regs", reg_o, flat());
    bus.bready = 1; bus.rready = 1;
    tick();
    bus.bready = 0; bus.rready = 0;
    check("t5_both_done", {bus.bvalid, bus.rvalid}, 2'b00);
    do_read(32'h4, rd, resp);
    check("t5_reread", rd, 32'h5);
    do_read(32'h7, rd, resp);
    check("t5_unaligned", {rd, resp}, {32'h5, 2'b00});

    // Reset between AW and W drops the held address
    bus.awvalid = 1; bus.awaddr = 32'h14;
    tick();
    bus.awvalid = 0;
    check("t6_aw_held", {bus.awready, bus.wready}, 2'b01);
    rst_n = 0;
    #1;
    for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
    check("t6_async_regs", reg_o, flat());
    check("t6_async_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
    tick();
    rst_n = 1;
    tick();
    check("t6_readies_back", {bus.awready, bus.wready}, 2'b11);
    bus.wvalid = 1; bus.wdata = 32'hABCD_0123; bus.wstrb = 4'hF;
    tick();
    bus.wvalid = 0;
    tick();
    tick();
    check("t6_no_commit", {bus.bvalid, wr_pulse}, 17'h0);
    check("t6_w_only_held", {bus.awready, bus.wready}, 2'b10);
    check("t6_regs", reg_o, flat());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_regfile.md
# axi_lite_regfile

AXI4-Lite slave register bank that terminates the `axi_lite_if` slave modport and exposes a bank of 32-bit control registers to local hardware. It sits directly downstream of any AXI4-Lite master attached to the interface. It accepts independent write address and write data, one outstanding write and one outstanding read at a time, and applies byte strobes. It also returns OKAY/SLVERR responses.

## Interface
Parameters:
- `NUM_REGS`, 16: number of 32-bit registers; must be ≥1 and a power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of register 0; must be aligned to `NUM_REGS*4`.
- `RESET_VAL`, 32'h0: reset value loaded into every register.

Ports:
- `aclk`  input  1  clock.
- `resetn`  input  1  reset; asynchronous, active-low.
- `s_axi`  interface  `axi_lite_if.slave`  AXI4-Lite slave port; `addr_t`/`data_t` are 32 bits, `strb_t` is 4 bits, `resp_t` is 2 bits.
- `reg_o`  output  NUM_REGS*32  flattened register contents; register i occupies bits [32*i+31 : 32*i].
- `wr_pulse_o`  output  NUM_REGS  one-cycle pulse, registered; bit i is high the cycle after register i is written.

## Operation
- Decode: an address is in range if `(addr - BASE_ADDR) < NUM_REGS*4`. The index is `(addr - BASE_ADDR) >> 2`. `addr[1:0]` is ignored, so unaligned accesses hit the containing word.
- AW and W are captured independently into holding registers. They may arrive in either order or in the same cycle.
- `awready` = resetn & !aw_held & !bvalid. `wready` = resetn & !w_held & !bvalid.
- A write commits on the edge where the second of AW/W is accepted, or on the edge where both are accepted together.
  - In range: byte k of the register is updated iff `wstrb[k]`. `bresp`=OKAY (2'b00).
  - Out of range: no register changes and no pulse. `bresp`=SLVERR (2'b10).
  - On commit: `bvalid` is set, `wr_pulse_o[idx]` is set for one cycle (in-range only), and the holding flags clear.
- `bvalid` holds until `bready`. While `bvalid`=1, no new AW or W is accepted.
- Read: `arready` = resetn & !rvalid. On an AR handshake, `rdata`/`rresp` are registered and `rvalid` is set next cycle.
  - In range: `rdata` = current register value, `rresp`=OKAY.
  - Out of range: `rdata`=0, `rresp`=SLVERR.
- `rvalid`/`rdata`/`rresp` hold until `rready`.
- The read and write paths are fully independent and may complete in the same cycle.

## Timing
- While `resetn` is low:
  - `reg_o`=RESET_VAL for every register.
  - `wr_pulse_o`, `bvalid`, `rvalid`, `bresp`, `rresp`, `rdata` are all 0.
  - `awready`, `wready`, `arready` are 0.
  - Holding flags are cleared.
- A reset mid-transaction drops all held and pending state. No write commits.
- Write latency: `bvalid` rises 1 cycle after the completing handshake edge. `reg_o` and `wr_pulse_o` update on that same edge.
- Read latency: `rvalid` rises 1 cycle after the AR handshake.
- Back-to-back transactions:
  - A `bvalid`/`bready` handshake in cycle T frees the AW/W ready signals in cycle T+1, giving at most one write per 2 cycles.
  - A `rvalid`/`rready` handshake in cycle T frees `arready` in T+1.
- Read/write collision: an AR handshake on the same edge as a write commit to the same register returns the old value. A read accepted on a later edge sees the new value.
- Holding registers hold valid, stable data until commit, regardless of master behaviour after the handshake.

## Structure
- Add to `axi_lite_pkg`:
  - `RESP_OKAY`=2'b00 and `RESP_SLVERR`=2'b10.
  - `ADDR_LSB`=2.
  - `DATA_BYTES`=4.
  - The byte-strobe merge function `apply_strb(old, new, strb)`.
- Single module, no sub-modules. Write-capture logic, the register array, and the read mux all live in `axi_lite_regfile`.

## Test plan
- Reset, then AW addr 0x4 and W data 0xDEADBEEF strb 4'hF in the same cycle → `bvalid` next cycle with `bresp`=0, `reg_o[63:32]`=0xDEADBEEF, `wr_pulse_o`=16'h0002 for 1 cycle.
- W data 0x11223344 strb 4'b0101 three cycles before AW addr 0x8, register holding 0xAABBCCDD → register becomes 0xAA22CC44; `bvalid` rises 1 cycle after the AW handshake.
- Write addr 0x40 (NUM_REGS=16) → `bresp`=SLVERR, `reg_o` unchanged, no pulse. Read 0x40 → `rdata`=0, `rresp`=SLVERR.
- Hold `bready`=0 for 5 cycles → `awready`/`wready` stay 0 and `bvalid` stays 1. Hold `rready`=0 → `rdata` stays stable and `arready`=0.
- Read addr 0x4 on the same edge as a write commit of 0x5 to 0x4, old value 0x1 → `rdata`=0x1. Immediate re-read → 0x5.
- Assert `resetn` low after AW is accepted but before W arrives → after reset, W alone produces no commit and no `bvalid`, and `reg_o`=RESET_VAL.
